// File: rtl/dmem_pkg.sv
// Shared types for the stage-3 data-memory responder.
// - dmem_state_t : responder FSM state encoding
// - wb_entry_t   : one posted write (address + data) held in the write buffer
// The write-buffer entry widths are fixed here. The responder's ADDR_W/DATA_W
// parameters must match DMEM_ADDR_W/DMEM_DATA_W.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 8;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } dmem_state_t;

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/write_buffer_fifo.sv
// Circular write buffer for posted stores, with an associative lookup port.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the buffer)
//   push         enqueue push_entry at the tail (caller never pushes when full)
//   push_entry   {addr, data} to enqueue
//   pop          dequeue the head (caller never pops when empty)
//   head_entry   oldest entry
//   count        occupied entries
//   full, empty  occupancy flags
//   lookup_addr  address searched across all valid entries
//   hit          some valid entry matches lookup_addr
//   hit_data     data of the youngest matching entry
import dmem_pkg::*;

module write_buffer_fifo #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output wb_entry_t              head_entry,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty,
    input  logic [DMEM_ADDR_W-1:0] lookup_addr,
    output logic                   hit,
    output logic [DMEM_DATA_W-1:0] hit_data
);

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                entries[tail_ptr] <= push_entry;
                tail_ptr          <= tail_ptr + 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_entry = entries[head_ptr];
    assign count      = count_q;
    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);

    // Walk from oldest to youngest; a later match overrides an earlier one,
    // so the youngest matching store wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (entries[idx].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the stage-3 data-memory port. Owns the backing
// data array, posts stores through a write buffer, forwards buffered data to
// reads, and stalls the pipeline (mem_ready=0) for read misses.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   MemRead     read request
//   MemWrite    write request (wins over MemRead)
//   Address     request address
//   WriteData   write data
//   ReadData    read data, valid when MemRead & mem_ready
//   mem_ready   request completes this cycle; 0 stalls the pipeline
//   wb_count    occupied write-buffer entries
//   wb_empty    write buffer empty
//   proto_err   sticky; MemRead and MemWrite seen together in IDLE
//
// state   | meaning
// IDLE    | accept writes into the buffer, serve read hits, start read misses
// RD_WAIT | read miss in flight; array word captured, latency counting down
import dmem_pkg::*;

module data_mem_responder #(
    parameter  int ADDR_W       = 8,
    parameter  int DATA_W       = 8,
    parameter  int WB_DEPTH     = 4,
    parameter  int READ_LATENCY = 2,
    parameter  int DRAIN_CYCLES = 1,
    localparam int CNT_W        = $clog2(WB_DEPTH) + 1,
    localparam int LAT_W        = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1,
    localparam int DRN_W        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              mem_ready,
    output logic [CNT_W-1:0]  wb_count,
    output logic              wb_empty,
    output logic              proto_err
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES - 1);

    dmem_state_t       state, next_state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DRN_W-1:0]  drain_cnt;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_capt;
    logic [DATA_W-1:0] rd_last;

    logic              wb_push, wb_pop, wb_full, wb_hit;
    wb_entry_t         wb_head;
    logic [DATA_W-1:0] wb_hit_data;

    logic              rd_capture, hit_resp, miss_resp, proto_set;

    write_buffer_fifo #(.DEPTH(WB_DEPTH)) u_wb (
        .clk         (clk),
        .rst         (rst),
        .push        (wb_push),
        .push_entry  ('{addr: Address, data: WriteData}),
        .pop         (wb_pop),
        .head_entry  (wb_head),
        .count       (wb_count),
        .full        (wb_full),
        .empty       (wb_empty),
        .lookup_addr (Address),
        .hit         (wb_hit),
        .hit_data    (wb_hit_data)
    );

    // Head retires once its drain window expires; independent of the FSM.
    assign wb_pop = !wb_empty && (drain_cnt == '0);

    always_comb begin
        next_state = state;
        mem_ready  = 1'b1;
        wb_push    = 1'b0;
        rd_capture = 1'b0;
        hit_resp   = 1'b0;
        miss_resp  = 1'b0;
        proto_set  = 1'b0;
        case (state)
            IDLE: begin
                if (MemWrite) begin
                    proto_set = MemRead;
                    // Full is judged on the start-of-cycle count: a drain in
                    // the same cycle does not free a slot for this write.
                    if (wb_full) mem_ready = 1'b0;
                    else         wb_push   = 1'b1;
                end else if (MemRead) begin
                    if (wb_hit) begin
                        hit_resp = 1'b1;
                    end else begin
                        mem_ready  = 1'b0;
                        rd_capture = 1'b1;
                        next_state = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (!MemRead) begin
                    next_state = IDLE;
                end else if (lat_cnt != '0) begin
                    mem_ready = 1'b0;
                end else begin
                    miss_resp  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt   <= '0;
            drain_cnt <= DRN_LOAD;
            rd_capt   <= '0;
            rd_last   <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
        end else begin
            if (rd_capture) begin
                lat_cnt <= LAT_LOAD;
                rd_capt <= mem[Address];
            end else if ((state == RD_WAIT) && MemRead && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if (wb_empty || wb_pop) drain_cnt <= DRN_LOAD;
            else                    drain_cnt <= drain_cnt - 1'b1;

            // A miss means Address is not buffered, so this never hits the
            // same word as the capture above.
            if (wb_pop) mem[wb_head.addr] <= wb_head.data;

            if (hit_resp)       rd_last <= wb_hit_data;
            else if (miss_resp) rd_last <= rd_capt;

            if (proto_set) proto_err <= 1'b1;
        end
    end

    assign ReadData = hit_resp  ? wb_hit_data :
                      miss_resp ? rd_capt     : rd_last;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       MemRead, MemWrite;
    logic [7:0] Address, WriteData;
    logic [7:0] ReadData;
    logic       mem_ready;
    logic [2:0] wb_count;
    logic       wb_empty;
    logic       proto_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .ADDR_W(8), .DATA_W(8), .WB_DEPTH(4), .READ_LATENCY(2), .DRAIN_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .mem_ready (mem_ready),
        .wb_count  (wb_count),
        .wb_empty  (wb_empty),
        .proto_err (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        MemRead   = rd;
        MemWrite  = wr;
        Address   = a;
        WriteData = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_ready",    32'(mem_ready), 32'd1);
        chk("rst_count",    32'(wb_count),  32'd0);
        chk("rst_empty",    32'(wb_empty),  32'd1);
        chk("rst_proto",    32'(proto_err), 32'd0);
        chk("rst_rdata",    32'(ReadData),  32'h00);
        tick();

        // 1: write then immediate read hits the buffer
        drive(1'b0, 1'b1, 8'h05, 8'h12);
        chk("t1_wr_ready",  32'(mem_ready), 32'd1);
        tick();
        drive(1'b1, 1'b0, 8'h05, 8'h00);
        chk("t1_rd_ready",  32'(mem_ready), 32'd1);
        chk("t1_rd_data",   32'(ReadData),  32'h12);
        tick();
        idle(20);
        chk("t1_drained",   32'(wb_empty),  32'd1);

        // 2: five back-to-back writes with DRAIN_CYCLES=4
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'(8'h10 + i), 8'(8'h61 + i));
            chk($sformatf("t2_ready%0d", i), 32'(mem_ready), 32'd1);
            tick();
            chk($sformatf("t2_count%0d", i), 32'(wb_count), 32'(i + 1));
        end
        drive(1'b0, 1'b1, 8'h14, 8'h65);
        chk("t2_full_stall", 32'(mem_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("t2_full_done",  32'(mem_ready), 32'd1);
        tick();
        chk("t2_count_after", 32'(wb_count), 32'd4);
        idle(25);
        chk("t2_drained",    32'(wb_empty),  32'd1);

        // 3: read miss, latency 2
        drive(1'b0, 1'b1, 8'h20, 8'h5A);
        tick();
        idle(10);
        chk("t3_empty",      32'(wb_empty),  32'd1);
        drive(1'b1, 1'b0, 8'h20, 8'h00);
        chk("t3_ready_c0",   32'(mem_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("t3_ready_c1",   32'(mem_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("t3_ready_c2",   32'(mem_ready), 32'd1);
        chk("t3_data",       32'(ReadData),  32'h5A);
        tick();
        idle(1);

        // 4: youngest buffered store wins, then drains to the array
        drive(1'b0, 1'b1, 8'h07, 8'hAA);
        tick();
        drive(1'b0, 1'b1, 8'h07, 8'hBB);
        tick();
        drive(1'b1, 1'b0, 8'h07, 8'h00);
        chk("t4_hit_ready",  32'(mem_ready), 32'd1);
        chk("t4_hit_data",   32'(ReadData),  32'hBB);
        tick();
        idle(20);
        drive(1'b1, 1'b0, 8'h07, 8'h00);
        chk("t4_miss_c0",    32'(mem_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("t4_miss_c1",    32'(mem_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("t4_miss_ready", 32'(mem_ready), 32'd1);
        chk("t4_array_data", 32'(ReadData),  32'hBB);
        tick();
        idle(1);

        // 5: read+write together -> write wins, sticky proto_err
        drive(1'b1, 1'b1, 8'h09, 8'h33);
        chk("t5_ready",      32'(mem_ready), 32'd1);
        tick();
        chk("t5_count",      32'(wb_count),  32'd1);
        chk("t5_proto",      32'(proto_err), 32'd1);
        drive(1'b1, 1'b0, 8'h09, 8'h00);
        chk("t5_hit_data",   32'(ReadData),  32'h33);
        tick();
        idle(10);
        chk("t5_proto_sticky", 32'(proto_err), 32'd1);

        // 6: reset during a read miss discards everything
        drive(1'b0, 1'b1, 8'h30, 8'h01);
        tick();
        drive(1'b0, 1'b1, 8'h31, 8'h02);
        tick();
        drive(1'b0, 1'b1, 8'h32, 8'h03);
        tick();
        drive(1'b1, 1'b0, 8'h05, 8'h00);
        chk("t6_miss_c0",    32'(mem_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("t6_in_wait",    32'(mem_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("t6_count",      32'(wb_count),  32'd0);
        chk("t6_empty",      32'(wb_empty),  32'd1);
        chk("t6_rdata",      32'(ReadData),  32'h00);
        chk("t6_proto",      32'(proto_err), 32'd0);
        chk("t6_idle_ready", 32'(mem_ready), 32'd1);
        tick();
        drive(1'b1, 1'b0, 8'h05, 8'h00);
        chk("t6_rd_c0",      32'(mem_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("t6_rd_c1",      32'(mem_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("t6_rd_ready",   32'(mem_ready), 32'd1);
        chk("t6_rd_cleared", 32'(ReadData),  32'h00);
        tick();
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
